imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory loader for the mips_16 core. It accepts a framed stream of 16-bit words over a valid/ready handshake and writes the payload into instruction memory from address 0. The core is held in reset until a checksum-verified image is in place. It sits between the host/test interface and the core's instruction memory write port, and drives the core's active-high `reset`.

## Interface

Parameters:
- `ADDR_W`, default 8: instruction memory address width.
- `DEPTH`, default 256: maximum image length in words; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `load_start`  in  1  one-cycle pulse that begins or restarts a load.
- `in_valid`  in  1  source has a word on `in_data`.
- `in_data`  in  16  stream word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `mem_we`  out  1  instruction memory write enable.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  16  write data.
- `cpu_reset`  out  1  active-high reset to the mips_16 core.
- `done`  out  1  image loaded and verified; core running.
- `error`  out  1  bad length or checksum mismatch.
- `word_count`  out  ADDR_W+1  payload words written since the last `load_start`.

## Operation

- Frame format:
  - Word 0 is the length `N`.
  - Words 1..N are the payload.
  - Word N+1 is the checksum: 16-bit sum mod 2^16 of the payload words.
- A transfer occurs on a cycle with `in_valid && in_ready`.
- `in_ready` is combinational: high in LEN, DATA or CSUM and `!load_start`; low otherwise.
- States:
  - IDLE: reset state. `load_start` → LEN.
  - LEN: on transfer, latch `N`.
    - `N == 0` or `N > DEPTH` → ERR.
    - Otherwise clear the running sum and the address → DATA.
  - DATA: on transfer:
    - register `mem_wdata = in_data` and `mem_addr = current address`, assert `mem_we`;
    - add the word to the sum;
    - increment the address and `word_count`;
    - after the N-th word → CSUM.
  - CSUM: on transfer, compare with the sum. Match → RUN; mismatch → ERR.
  - RUN: `cpu_reset=0`, `done=1`. Stays until `load_start`.
  - ERR: `cpu_reset=1`, `error=1`. Stays until `load_start`.
- `load_start` in any state other than IDLE:
  - next state LEN;
  - `cpu_reset` is set to 1, `done` and `error` are cleared, `word_count` is cleared;
  - all of this is registered, effective the next cycle.
- `load_start` has priority over a simultaneous handshake. No word is accepted that cycle because `in_ready` is low.
- Memory previously written is not cleared on restart or error.
- `word_count` saturates at `N`. It never exceeds `DEPTH`.

## Timing

- Reset (`reset==0` at a clock edge) gives the next cycle:
  - state IDLE;
  - `mem_we=0`, `mem_addr=0`, `mem_wdata=0`;
  - `cpu_reset=1`, `done=0`, `error=0`, `word_count=0`.
- Reset mid-load aborts immediately. No further `mem_we` is issued.
- `mem_we` is a registered one-cycle pulse in the cycle after each accepted payload word.
  - Back-to-back transfers give back-to-back writes at consecutive addresses.
  - With no transfer, `mem_we=0`.
- The address wraps nowhere: the length check guarantees the last address is `N-1 ≤ DEPTH-1`.
- The final write (`mem_we` for word N) lands in the first CSUM cycle. The earliest checksum transfer is that same cycle.
- `cpu_reset` deasserts and `done` asserts in the cycle after the accepted matching checksum. The last memory write has therefore always completed before the core leaves reset.
- `error` asserts in the cycle after an accepted bad length or bad checksum.
- Source stalls (`in_valid=0`) of any length are tolerated in LEN, DATA and CSUM. State and the sum are held.

## Test plan

1. **Good load:** `load_start`, then stream `3, 0x1111, 0x2222, 0x3333, 0x6666` with `in_valid` held high.
   - Writes at addresses 0,1,2 on three consecutive cycles.
   - `word_count=3`.
   - `cpu_reset` falls and `done=1` one cycle after the checksum transfer.
2. **Bad checksum:** stream `2, 0xFFFF, 0x0002, 0x0000`.
   - Two writes occur.
   - `error=1`, `cpu_reset` stays 1, `done=0`.
   - The sum wraps: the correct checksum is 0x0001.
3. **Bad length:** stream `0`, then separately `DEPTH+1`.
   - ERR after the length word, with no `mem_we`.
   - `in_ready=0` while in ERR.
4. **Stalls:** payload of 4 words with `in_valid` toggling randomly.
   - Exactly 4 writes at addresses 0..3 with correct data.
   - Verified completion (`done=1`) with checksum 0x000A for payload `1, 2, 3, 4`.
5. **Restart and simultaneity:**
   - Assert `load_start` on the same cycle as the 2nd payload handshake: that word is not written, and the next word is treated as the length.
   - Also: `load_start` while in RUN re-asserts `cpu_reset` and clears `done` the next cycle.
6. **Reset mid-load:** drive `reset=0` for one cycle during DATA.
   - Outputs take their reset values the following cycle.
   - No further `mem_we` is issued.
   - `in_data` is ignored until a new `load_start`.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a framed word stream (length, payload, checksum),
// writes the payload into instruction memory from address 0, and holds the
// mips_16 core in reset until the image has passed the checksum.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [15:0]       sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic              xfer;

  // A restart pulse blocks the handshake so its word can never be consumed.
  always_comb begin
    in_ready = ((state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM)) && !load_start;
    xfer     = in_valid && in_ready;
  end

  // Next-state logic: frame parsing, payload writes, checksum verdict, restart override.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sum_d        = sum_q;
    addr_d       = addr_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    error_d      = error_q;
    word_count_d = word_count_q;

    case (state_q)
      S_IDLE: begin
      end
      S_LEN: begin
        if (xfer) begin
          if ((in_data == 16'd0) || ({1'b0, in_data} > DEPTH_W)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            len_d   = CNT_W'(in_data);
            sum_d   = 16'd0;
            addr_d  = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          sum_d       = sum_q + in_data;
          addr_d      = addr_q + 1'b1;
          if (word_count_q < len_q) begin
            word_count_d = word_count_q + 1'b1;
          end
          if ((word_count_q + 1'b1) == len_q) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d     = S_RUN;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      S_RUN: begin
      end
      S_ERR: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_start) begin
      state_d      = S_LEN;
      cpu_reset_d  = 1'b1;
      done_d       = 1'b0;
      error_d      = 1'b0;
      word_count_d = '0;
    end
  end

  // State registers with synchronous active-low reset; reset keeps the core held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      sum_q        <= 16'd0;
      addr_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 16'd0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      addr_q       <= addr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven frames, hand-written restart/reset sequences and
// randomized frames checked against a frame-level reference model.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk;
  logic              reset;
  logic              load_start;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int vectors;
  int miscompares;
  int cyc;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    int                cyc;
  } wr_t;

  typedef struct {
    logic [5:0][15:0] words;
    int               nwords;
    int               stall;
    bit               exp_done;
    bit               exp_err;
    int               exp_wc;
  } vec_t;

  wr_t  wr_q[$];
  wr_t  mon_w;
  vec_t tbl[7];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .load_start(load_start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error),
    .word_count(word_count)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to timestamp memory writes.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory-port monitor: records every write with its cycle number.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      mon_w.addr = mem_addr;
      mon_w.data = mem_wdata;
      mon_w.cyc  = cyc;
      wr_q.push_back(mon_w);
    end
  end

  // Hard stop in case the bench itself gets stuck.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present one word until it is accepted, with random source stalls.
  task automatic applyStimulus(input logic [15:0] w, input int stall);
    bit accepted;
    int guard;
    accepted = 1'b0;
    guard    = 0;
    while (!accepted && guard < 300) begin
      @(negedge clk);
      in_data  = w;
      in_valid = (int'($urandom_range(99)) >= stall);
      #1;
      accepted = in_valid && in_ready;
      guard++;
    end
    if (!accepted) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL handshake_timeout: got no in_ready expected accept of 0x%0h", w);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, b, c, d, e, f,
                              input int nw, input int st, input bit dn, input bit er, input int wc);
    vec_t v;
    v.words[0] = a; v.words[1] = b; v.words[2] = c;
    v.words[3] = d; v.words[4] = e; v.words[5] = f;
    v.nwords = nw; v.stall = st; v.exp_done = dn; v.exp_err = er; v.exp_wc = wc;
    return v;
  endfunction

  // Whole frame: restart, stream, then check verdict and the recorded writes.
  task automatic runFrame(input logic [15:0] q[$], input int stall,
                          input bit exp_done, input bit exp_err, input int exp_wc);
    int n;
    int npush;
    int nexp;
    bit badlen;
    @(negedge clk);
    load_start = 1'b1;
    in_valid   = 1'b0;
    #1;
    checkOutput("ready_during_start", 32'(in_ready), 32'd0);
    @(negedge clk);
    load_start = 1'b0;
    checkOutput("start_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("start_done", 32'(done), 32'd0);
    checkOutput("start_error", 32'(error), 32'd0);
    checkOutput("start_word_count", 32'(word_count), 32'd0);
    wr_q.delete();
    n      = int'(q[0]);
    badlen = (n == 0) || (n > DEPTH);
    npush  = badlen ? 1 : n + 2;
    nexp   = badlen ? 0 : n;
    for (int i = 0; i < npush; i++) applyStimulus(q[i], stall);
    checkOutput("pre_verdict_done", 32'(done), 32'd0);
    checkOutput("pre_verdict_error", 32'(error), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("verdict_done", 32'(done), 32'(exp_done));
    checkOutput("verdict_error", 32'(error), 32'(exp_err));
    checkOutput("verdict_cpu_reset", 32'(cpu_reset), 32'(!exp_done));
    checkOutput("verdict_word_count", 32'(word_count), 32'(exp_wc));
    checkOutput("verdict_in_ready", 32'(in_ready), 32'd0);
    checkOutput("write_count", 32'(wr_q.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < wr_q.size(); i++) begin
      checkOutput("write_addr", 32'(wr_q[i].addr), 32'(i));
      checkOutput("write_data", 32'(wr_q[i].data), 32'(q[i + 1]));
      if (stall == 0 && i > 0)
        checkOutput("write_back_to_back", 32'(wr_q[i].cyc - wr_q[i - 1].cyc), 32'd1);
    end
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] sum;
    logic [15:0] csum;
    logic [15:0] d;
    int          n;
    bit          bad;
    bit          edone;

    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b0;
    load_start  = 1'b0;
    in_valid    = 1'b0;
    in_data     = 16'd0;

    repeat (3) @(negedge clk);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;

    tbl[0] = mk(16'd3, 16'h1111, 16'h2222, 16'h3333, 16'h6666, 16'h0, 5, 0, 1'b1, 1'b0, 3);
    tbl[1] = mk(16'd2, 16'hFFFF, 16'h0002, 16'h0000, 16'h0, 16'h0, 4, 0, 1'b0, 1'b1, 2);
    tbl[2] = mk(16'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0, 1'b0, 1'b1, 0);
    tbl[3] = mk(16'(DEPTH + 1), 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0, 1'b0, 1'b1, 0);
    tbl[4] = mk(16'd4, 16'd1, 16'd2, 16'd3, 16'd4, 16'h000A, 6, 50, 1'b1, 1'b0, 4);
    tbl[5] = mk(16'd1, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 3, 30, 1'b1, 1'b0, 1);
    tbl[6] = mk(16'd2, 16'hFFFF, 16'h0002, 16'h0001, 16'h0, 16'h0, 4, 0, 1'b1, 1'b0, 2);

    for (int k = 0; k < 7; k++) begin
      q.delete();
      for (int i = 0; i < tbl[k].nwords; i++) q.push_back(tbl[k].words[i]);
      runFrame(q, tbl[k].stall, tbl[k].exp_done, tbl[k].exp_err, tbl[k].exp_wc);
    end

    // Restart coinciding with the second payload handshake.
    wr_q.delete();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    applyStimulus(16'd3, 0);
    applyStimulus(16'hAAAA, 0);
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = 16'hBBBB;
    load_start = 1'b1;
    #1;
    checkOutput("restart_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    load_start = 1'b0;
    in_valid   = 1'b0;
    checkOutput("restart_word_count", 32'(word_count), 32'd0);
    checkOutput("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    applyStimulus(16'd2, 0);
    applyStimulus(16'h0005, 0);
    applyStimulus(16'h0007, 0);
    applyStimulus(16'h000C, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("restart_done", 32'(done), 32'd1);
    checkOutput("restart_final_count", 32'(word_count), 32'd2);
    checkOutput("restart_writes", 32'(wr_q.size()), 32'd3);
    if (wr_q.size() == 3) begin
      checkOutput("restart_w0_data", 32'(wr_q[0].data), 32'hAAAA);
      checkOutput("restart_w1_addr", 32'(wr_q[1].addr), 32'd0);
      checkOutput("restart_w1_data", 32'(wr_q[1].data), 32'h0005);
      checkOutput("restart_w2_addr", 32'(wr_q[2].addr), 32'd1);
      checkOutput("restart_w2_data", 32'(wr_q[2].data), 32'h0007);
    end

    // Restart from RUN puts the core back into reset.
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    #1;
    checkOutput("run_restart_done", 32'(done), 32'd0);
    checkOutput("run_restart_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("run_restart_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of the payload.
    applyStimulus(16'd4, 0);
    applyStimulus(16'h1234, 0);
    applyStimulus(16'h5678, 0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h9999;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("midrst_word_count", 32'(word_count), 32'd0);
    wr_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_data = 16'($urandom);
      #1;
      checkOutput("midrst_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("midrst_no_writes", 32'(wr_q.size()), 32'd0);
    checkOutput("midrst_error", 32'(error), 32'd0);

    // Randomized frames against the frame-level model; the last is a full-depth image.
    for (int f = 0; f < 21; f++) begin
      case ($urandom_range(9))
        0:       n = 0;
        1:       n = DEPTH + 1 + int'($urandom_range(100));
        default: n = int'($urandom_range(8, 1));
      endcase
      if (f == 20) n = DEPTH;
      bad = (n == 0) || (n > DEPTH);
      q.delete();
      q.push_back(16'(n));
      sum = 16'd0;
      if (!bad) begin
        for (int i = 0; i < n; i++) begin
          d   = 16'($urandom);
          sum = sum + d;
          q.push_back(d);
        end
        csum = sum;
        if ($urandom_range(3) == 0) csum = sum ^ (16'd1 << $urandom_range(15));
        q.push_back(csum);
      end else begin
        csum = 16'd0;
      end
      edone = !bad && (csum == sum);
      runFrame(q, (f == 20) ? 0 : int'($urandom_range(60)), edone, !edone, bad ? 0 : n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
